cam_capture_ctrl: RTL
=====================

Name: cam_capture_ctrl

Overview:
- Parametrised camera front-end. Samples the asynchronous parallel-camera bus (apclk, ahref, avsync, adata) in the system clock domain.
- Assembles multi-byte pixels and tags them with frame/line coordinates.
- Applies runtime power-of-two decimation, then presents pixels on a valid/ready stream to downstream colour conversion.
- Successor to the fixed 2-byte, single-mode capture path: adds width/depth parameters, decimation, frame gating, back-pressure and error status.

Parameters:
- DATA_W, 8, camera data bus width.
- BYTES_PER_PIX, 2, bus beats per pixel, MSB beat first (1..4).
- X_W, 10, pixel column counter width.
- Y_W, 9, line counter width.
- SYNC_STAGES, 2, synchroniser depth for apclk/ahref/avsync/adata (≥2).
- VSYNC_ACTIVE, 1, avsync level during vertical blanking.

Ports:
- clk  in  1  system clock.
- res  in  1  synchronous active-low reset.
- apclk  in  1  camera pixel clock, asynchronous.
- ahref  in  1  line-valid, asynchronous.
- avsync  in  1  frame sync, asynchronous.
- adata  in  DATA_W  camera data, asynchronous.
- enable  in  1  capture enable; sampled at frame boundaries.
- decim  in  2  subsample factor 2^decim in both axes (1, 2, 4, 8).
- clr_status  in  1  clears sticky status bits.
- pix_valid  out  1  pixel available.
- pix_ready  in  1  downstream accepts pixel.
- pix_data  out  BYTES_PER_PIX*DATA_W  assembled pixel.
- pix_x  out  X_W  decimated column.
- pix_y  out  Y_W  decimated line.
- pix_sof  out  1  first emitted pixel of frame; qualified by pix_valid.
- line_done  out  1  one-cycle pulse at line end.
- frame_done  out  1  one-cycle pulse at frame end.
- status  out  3  sticky flags: [0] overrun, [1] partial pixel, [2] x overflow.

Behaviour:
- Reset (res=0 at posedge clk) clears all state. All outputs 0, FSM=IDLE; synchroniser chains load inactive levels (avsync chain loads VSYNC_ACTIVE).
- Synchronisers: apclk, ahref, avsync and adata each pass through SYNC_STAGES flops, so all four stay mutually aligned.
- Beat detect: a beat is a rising edge of synced apclk (current 1, previous 0) while synced ahref=1 and FSM=ACTIVE. The synced adata is taken on that cycle.
- Byte assembly: beat counter 0..BYTES_PER_PIX-1, MSB beat first. The last beat completes the pixel.
- Pixel emission:
  - Emitted only if src_x[decim-1:0]==0 and src_y[decim-1:0]==0; decim=0 emits every pixel.
  - pix_x = src_x>>decim, pix_y = src_y>>decim.
  - pix_valid rises the cycle after the last beat is detected.
  - Output is a single register. It is held stable while pix_valid=1 and pix_ready=0, and clears on a handshake unless a new pixel loads in the same cycle.
  - If a new pixel completes while pix_valid=1 and pix_ready=0: the new pixel is dropped, status[0] is set, and the held pixel is unchanged.
- pix_sof is set on the first emitted pixel after frame start and cleared after that pixel's handshake.
- Column counter src_x:
  - Increments per completed pixel.
  - At 2^X_W-1, further pixels in the line are dropped and status[2] is set. The counter saturates and does not wrap.
- Line end (synced ahref falling edge in ACTIVE):
  - If the beat counter is nonzero, the partial pixel is discarded and status[1] is set.
  - src_x and the beat counter are cleared.
  - src_y increments (saturating) only if ≥1 beat was seen in the line.
  - line_done pulses.
- FSM:
  - IDLE → WAIT_VS when enable=1.
  - WAIT_VS → WAIT_FRAME when synced avsync==VSYNC_ACTIVE.
  - WAIT_FRAME → ACTIVE when avsync deasserts. This is the frame start: src_x, src_y and the beat counter clear, and the sof flag is armed.
  - ACTIVE → WAIT_FRAME on avsync reassert: frame_done pulses and any partial pixel is handled as at line end.
  - On that transition, if enable=0, go to IDLE instead.
  - Deasserting enable mid-frame never truncates a frame. Capture always starts on a full frame, never mid-frame.
- Status: sticky; clr_status=1 clears all bits in that cycle. A set event in the same cycle as clr_status wins.
- A pending pix_valid survives frame_done and line_done; it is only cleared by handshake or reset.

Test Plan:
- Reset/idle: res=0 for 3 clks with random bus activity → all outputs 0, no pix_valid. enable=0 over a full frame → no output.
- Basic frame: BYTES_PER_PIX=2, decim=0, pix_ready=1; 4 lines × 4 pixels with bytes {0xA1,0xB2} → 16 pixels, pix_data=0xA1B2, x 0..3, y 0..3, pix_sof on (0,0) only, 4 line_done pulses, 1 frame_done, status=0.
- Decimation: decim=1 on a 4×4 frame → 4 pixels at source (0,0),(2,0),(0,2),(2,2), reported as (0,0),(1,0),(0,1),(1,1).
- Back-pressure: pix_ready=0 across 2 completed pixels → first pixel held unchanged, second dropped, status=3'b001. clr_status then clears it to 0.
- Partial pixel: 3 beats in a line with BYTES_PER_PIX=2 → 1 pixel emitted, status[1]=1, next line's x starts at 0.
- Mid-frame start/stop: enable asserted mid-frame → no pixels until after the next vsync. enable dropped mid-frame → current frame completes with frame_done, then FSM=IDLE.

Source files
------------

// File: rtl/cam_capture_ctrl_if.sv
// Camera capture bundle: raw parallel-camera bus in, assembled pixel stream out.
//   apclk/ahref/avsync/adata : asynchronous camera pixel clock, line valid, frame sync, data
//   pix_valid/pix_ready      : pixel stream handshake
//   pix_data/pix_x/pix_y     : assembled pixel and its decimated coordinates
//   pix_sof                  : first emitted pixel of a frame
// master = the capture controller (sinks the camera bus, sources the pixel stream).
// slave  = the environment (drives the camera bus, consumes the pixel stream).
interface cam_capture_ctrl_if #(
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned BYTES_PER_PIX = 2,
  parameter int unsigned X_W           = 10,
  parameter int unsigned Y_W           = 9
);
  logic                            apclk;
  logic                            ahref;
  logic                            avsync;
  logic [DATA_W-1:0]               adata;
  logic                            pix_valid;
  logic                            pix_ready;
  logic [BYTES_PER_PIX*DATA_W-1:0] pix_data;
  logic [X_W-1:0]                  pix_x;
  logic [Y_W-1:0]                  pix_y;
  logic                            pix_sof;

  modport master (
    input  apclk, ahref, avsync, adata, pix_ready,
    output pix_valid, pix_data, pix_x, pix_y, pix_sof
  );

  modport slave (
    output apclk, ahref, avsync, adata, pix_ready,
    input  pix_valid, pix_data, pix_x, pix_y, pix_sof
  );
endinterface

// File: rtl/cam_capture_ctrl.sv
// Camera front-end: synchronises the parallel-camera bus into clk, assembles
// multi-beat pixels (MSB beat first), tags them with frame/line coordinates,
// applies power-of-two decimation and presents them on a valid/ready stream.
// Ports:
//   clk, res       : system clock, synchronous active-low reset
//   bus            : camera bus + pixel stream (cam_capture_ctrl_if.master)
//   i_enable       : capture enable, acted on at frame boundaries only
//   i_decim        : subsample factor 2^i_decim in both axes
//   i_clr_status   : clears sticky status bits
//   o_line_done    : one-cycle pulse at each line end
//   o_frame_done   : one-cycle pulse at each frame end
//   o_status       : sticky {x overflow, partial pixel, overrun}
module cam_capture_ctrl #(
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned BYTES_PER_PIX = 2,
  parameter int unsigned X_W           = 10,
  parameter int unsigned Y_W           = 9,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter bit          VSYNC_ACTIVE  = 1'b1
) (
  input  logic                   clk,
  input  logic                   res,
  cam_capture_ctrl_if.master     bus,
  input  logic                   i_enable,
  input  logic [1:0]             i_decim,
  input  logic                   i_clr_status,
  output logic                   o_line_done,
  output logic                   o_frame_done,
  output logic [2:0]             o_status
);

  localparam int unsigned PIX_W = BYTES_PER_PIX * DATA_W;
  localparam int unsigned BC_W  = (BYTES_PER_PIX > 1) ? $clog2(BYTES_PER_PIX) : 1;
  localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(BYTES_PER_PIX - 1);
  localparam logic [X_W-1:0]  X_MAX     = '1;
  localparam logic [Y_W-1:0]  Y_MAX     = '1;

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_WAIT_VS    = 2'd1;
  localparam logic [1:0] S_WAIT_FRAME = 2'd2;
  localparam logic [1:0] S_ACTIVE     = 2'd3;

  // Synchroniser chains: index 0 is the first stage, SYNC_STAGES-1 the output.
  logic [SYNC_STAGES-1:0]             r_pclk_sync;
  logic [SYNC_STAGES-1:0]             r_href_sync;
  logic [SYNC_STAGES-1:0]             r_vsync_sync;
  logic [SYNC_STAGES-1:0][DATA_W-1:0] r_data_sync;

  logic              r_pclk_d;
  logic              r_href_d;
  logic [1:0]        r_state;
  logic [BC_W-1:0]   r_beat_cnt;
  logic [PIX_W-1:0]  r_asm;
  logic [X_W-1:0]    r_src_x;
  logic [Y_W-1:0]    r_src_y;
  logic              r_line_seen;
  logic              r_sof_armed;

  logic              r_pix_valid;
  logic [PIX_W-1:0]  r_pix_data;
  logic [X_W-1:0]    r_pix_x;
  logic [Y_W-1:0]    r_pix_y;
  logic              r_pix_sof;
  logic              r_line_done;
  logic              r_frame_done;
  logic [2:0]        r_status;

  logic              w_pclk;
  logic              w_href;
  logic              w_vsync;
  logic [DATA_W-1:0] w_data;
  logic [1:0]        w_state_nxt;
  logic              w_frame_start;
  logic              w_frame_end;
  logic              w_active;
  logic              w_beat;
  logic              w_line_end;
  logic              w_pix_done;
  logic [PIX_W-1:0]  w_asm_next;
  logic              w_x_full;
  logic [X_W-1:0]    w_mask_x;
  logic [Y_W-1:0]    w_mask_y;
  logic              w_keep;
  logic              w_emit;
  logic              w_hs;
  logic              w_load;
  logic [2:0]        w_status_set;

  assign w_pclk  = r_pclk_sync[SYNC_STAGES-1];
  assign w_href  = r_href_sync[SYNC_STAGES-1];
  assign w_vsync = r_vsync_sync[SYNC_STAGES-1];
  assign w_data  = r_data_sync[SYNC_STAGES-1];

  // Synchronisers; equal depth keeps data aligned with the strobes.
  always_ff @(posedge clk) begin
    if (!res) begin
      r_pclk_sync  <= '0;
      r_href_sync  <= '0;
      r_vsync_sync <= {SYNC_STAGES{VSYNC_ACTIVE}};
      r_data_sync  <= '0;
    end else begin
      r_pclk_sync  <= {r_pclk_sync[SYNC_STAGES-2:0], bus.apclk};
      r_href_sync  <= {r_href_sync[SYNC_STAGES-2:0], bus.ahref};
      r_vsync_sync <= {r_vsync_sync[SYNC_STAGES-2:0], bus.avsync};
      r_data_sync  <= {r_data_sync[SYNC_STAGES-2:0], bus.adata};
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!res) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // FSM next state and frame boundary strobes. Enable only takes effect at
  // frame boundaries so a frame is never started or cut part way through.
  always_comb begin
    w_state_nxt   = r_state;
    w_frame_start = 1'b0;
    w_frame_end   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_enable) w_state_nxt = S_WAIT_VS;
      end
      S_WAIT_VS: begin
        if (!i_enable)                   w_state_nxt = S_IDLE;
        else if (w_vsync == VSYNC_ACTIVE) w_state_nxt = S_WAIT_FRAME;
      end
      S_WAIT_FRAME: begin
        if (w_vsync != VSYNC_ACTIVE) begin
          if (i_enable) begin
            w_state_nxt   = S_ACTIVE;
            w_frame_start = 1'b1;
          end else begin
            w_state_nxt   = S_IDLE;
          end
        end
      end
      S_ACTIVE: begin
        if (w_vsync == VSYNC_ACTIVE) begin
          w_frame_end = 1'b1;
          w_state_nxt = i_enable ? S_WAIT_FRAME : S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Beat / pixel / emission decode.
  always_comb begin
    w_active     = (r_state == S_ACTIVE);
    // A beat arriving with the closing vsync belongs to no frame.
    w_beat       = w_active && !w_frame_end && w_pclk && !r_pclk_d && w_href;
    w_line_end   = w_active && r_href_d && !w_href;
    w_pix_done   = w_beat && (r_beat_cnt == LAST_BEAT);
    w_asm_next   = (r_asm << DATA_W) | PIX_W'(w_data);
    w_x_full     = (r_src_x == X_MAX);
    w_mask_x     = ~(X_MAX << i_decim);
    w_mask_y     = ~(Y_MAX << i_decim);
    w_keep       = ((r_src_x & w_mask_x) == '0) && ((r_src_y & w_mask_y) == '0);
    w_emit       = w_pix_done && !w_x_full && w_keep;
    w_hs         = r_pix_valid && bus.pix_ready;
    w_load       = w_emit && (!r_pix_valid || bus.pix_ready);
    w_status_set = {w_pix_done && w_x_full,
                    (w_line_end || w_frame_end) && (r_beat_cnt != '0),
                    w_emit && r_pix_valid && !bus.pix_ready};
  end

  // Coordinate tracking, byte assembly, output register and status.
  always_ff @(posedge clk) begin
    if (!res) begin
      r_pclk_d     <= 1'b0;
      r_href_d     <= 1'b0;
      r_beat_cnt   <= '0;
      r_asm        <= '0;
      r_src_x      <= '0;
      r_src_y      <= '0;
      r_line_seen  <= 1'b0;
      r_sof_armed  <= 1'b0;
      r_pix_valid  <= 1'b0;
      r_pix_data   <= '0;
      r_pix_x      <= '0;
      r_pix_y      <= '0;
      r_pix_sof    <= 1'b0;
      r_line_done  <= 1'b0;
      r_frame_done <= 1'b0;
      r_status     <= '0;
    end else begin
      r_pclk_d     <= w_pclk;
      r_href_d     <= w_href;
      r_line_done  <= w_line_end;
      r_frame_done <= w_frame_end;
      r_status     <= (i_clr_status ? 3'b000 : r_status) | w_status_set;

      if (w_frame_start) begin
        r_beat_cnt  <= '0;
        r_src_x     <= '0;
        r_src_y     <= '0;
        r_line_seen <= 1'b0;
        r_sof_armed <= 1'b1;
      end else begin
        if (w_line_end || w_frame_end) begin
          // Any partial pixel is dropped here; only lines with data advance y.
          r_beat_cnt  <= '0;
          r_src_x     <= '0;
          r_line_seen <= 1'b0;
          if (w_line_end && r_line_seen && (r_src_y != Y_MAX))
            r_src_y <= r_src_y + 1'b1;
        end else if (w_beat) begin
          r_line_seen <= 1'b1;
          r_asm       <= w_asm_next;
          r_beat_cnt  <= (r_beat_cnt == LAST_BEAT) ? '0 : r_beat_cnt + 1'b1;
          if (w_pix_done && !w_x_full)
            r_src_x <= r_src_x + 1'b1;
        end
        if (w_load) r_sof_armed <= 1'b0;
      end

      // Single output register: hold under back-pressure, refill on handshake.
      if (w_load) begin
        r_pix_valid <= 1'b1;
        r_pix_data  <= w_asm_next;
        r_pix_x     <= r_src_x >> i_decim;
        r_pix_y     <= r_src_y >> i_decim;
        r_pix_sof   <= r_sof_armed;
      end else if (w_hs) begin
        r_pix_valid <= 1'b0;
        r_pix_sof   <= 1'b0;
      end
    end
  end

  assign bus.pix_valid = r_pix_valid;
  assign bus.pix_data  = r_pix_data;
  assign bus.pix_x     = r_pix_x;
  assign bus.pix_y     = r_pix_y;
  assign bus.pix_sof   = r_pix_sof;
  assign o_line_done   = r_line_done;
  assign o_frame_done  = r_frame_done;
  assign o_status      = r_status;

endmodule
